// File: rtl/csa5_pkg.sv
// rtl/csa5_pkg.sv - shared widths, FSM states and carry-save helper for csa5_accum_seq
package csa5_pkg;

    localparam int OP_W  = 14;   // operand width
    localparam int CS_W  = 17;   // carry-save vector width, holds 5 * (2^14 - 1)
    localparam int GRP_N = 5;    // operands per compressor group
    localparam int IDX_W = 3;    // slot index width

    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(GRP_N - 1);

    typedef enum logic [1:0] {
        FILL     = 2'd0,
        COMPRESS = 2'd1,
        ADD      = 2'd2,
        DONE     = 2'd3
    } seq_state_t;

    typedef struct packed {
        logic [CS_W-1:0] s;
        logic [CS_W-1:0] c;
    } cs_pair_t;

    // 3:2 compressor: s + c == x + y + z as long as the true total fits in CS_W bits,
    // so dropping the carry shifted out of the top bit loses nothing.
    function automatic cs_pair_t csa3(input logic [CS_W-1:0] x,
                                      input logic [CS_W-1:0] y,
                                      input logic [CS_W-1:0] z);
        cs_pair_t        r;
        logic [CS_W-1:0] m;
        r.s = x ^ y ^ z;
        m   = (x & y) | (x & z) | (y & z);
        r.c = {m[CS_W-2:0], 1'b0};
        return r;
    endfunction

endpackage

// File: rtl/adder5x14.sv
// rtl/adder5x14.sv - combinational 5-operand 14-bit carry-save compressor
//
// Ports:
//   a..e  in  14 b  unsigned operands
//   out1  out 17 b  sum vector
//   out2  out 17 b  carry vector; out1 + out2 == a + b + c + d + e
module adder5x14
    import csa5_pkg::*;
(
    input  logic [OP_W-1:0] a,
    input  logic [OP_W-1:0] b,
    input  logic [OP_W-1:0] c,
    input  logic [OP_W-1:0] d,
    input  logic [OP_W-1:0] e,
    output logic [CS_W-1:0] out1,
    output logic [CS_W-1:0] out2
);

    cs_pair_t l1, l2, l3;

    // Three chained 3:2 stages fold five operands into two vectors.
    always_comb begin
        l1   = csa3(CS_W'(a), CS_W'(b), CS_W'(c));
        l2   = csa3(l1.s, l1.c, CS_W'(d));
        l3   = csa3(l2.s, l2.c, CS_W'(e));
        out1 = l3.s;
        out2 = l3.c;
    end

endmodule

// File: rtl/csa5_accum_seq.sv
// rtl/csa5_accum_seq.sv - streaming 5-operand carry-save sum sequencer with wide accumulator
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   in_valid/in_ready   operand handshake, in_data 14 b, in_last marks final operand
//   res_valid/res_ready result handshake
//   res_data            ACC_W-bit sum modulo 2^ACC_W
//   res_ovf             sticky carry-out of the accumulator for this sum
module csa5_accum_seq
    import csa5_pkg::*;
#(
    parameter int ACC_W = 24
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [OP_W-1:0]  in_data,
    input  logic             in_last,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [ACC_W-1:0] res_data,
    output logic             res_ovf
);

    localparam int SUM_W = ACC_W + 1;

    seq_state_t       state, state_nxt;
    logic [OP_W-1:0]  slot [GRP_N];
    logic [IDX_W-1:0] idx;
    logic             grp_last;
    logic [CS_W-1:0]  cs1, cs2;
    logic [CS_W-1:0]  out1, out2;
    logic [ACC_W-1:0] acc;
    logic             ovf;
    logic [SUM_W-1:0] acc_sum;

    adder5x14 u_adder (
        .a    (slot[0]),
        .b    (slot[1]),
        .c    (slot[2]),
        .d    (slot[3]),
        .e    (slot[4]),
        .out1 (out1),
        .out2 (out2)
    );

    // Single carry-propagate add; the extra top bit is the overflow carry.
    assign acc_sum = {1'b0, acc} + SUM_W'(cs1) + SUM_W'(cs2);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= FILL;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        res_valid = 1'b0;
        case (state)
            FILL: begin
                in_ready = 1'b1;
                if (in_valid && (idx == IDX_LAST || in_last)) begin
                    state_nxt = COMPRESS;
                end
            end
            COMPRESS: state_nxt = ADD;
            ADD:      state_nxt = grp_last ? DONE : FILL;
            DONE: begin
                res_valid = 1'b1;
                if (res_ready) begin
                    state_nxt = FILL;
                end
            end
            default:  state_nxt = FILL;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            idx      <= '0;
            grp_last <= 1'b0;
            cs1      <= '0;
            cs2      <= '0;
            acc      <= '0;
            ovf      <= 1'b0;
            for (int i = 0; i < GRP_N; i++) begin
                slot[i] <= '0;
            end
        end else begin
            case (state)
                FILL: begin
                    if (in_valid) begin
                        slot[idx] <= in_data;
                        idx       <= idx + 1'b1;
                        grp_last  <= in_last;
                    end
                end
                COMPRESS: begin
                    cs1 <= out1;
                    cs2 <= out2;
                end
                ADD: begin
                    acc <= acc_sum[ACC_W-1:0];
                    ovf <= ovf | acc_sum[ACC_W];
                    // cs1/cs2 already hold this group, so the slot file can be
                    // emptied now; unfilled slots of the next group then read 0.
                    idx <= '0;
                    for (int i = 0; i < GRP_N; i++) begin
                        slot[i] <= '0;
                    end
                end
                DONE: begin
                    if (res_ready) begin
                        acc <= '0;
                        ovf <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign res_data = acc;
    assign res_ovf  = ovf;

endmodule

// File: tb/tb_csa5_accum_seq.sv
// tb/tb_csa5_accum_seq.sv - scoreboard bench for csa5_accum_seq
module tb_csa5_accum_seq;

    localparam int ACC_W = 18;
    localparam longint MOD = 64'd1 << ACC_W;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [13:0]      in_data;
    logic             in_last;
    logic             res_valid;
    logic             res_ready;
    logic [ACC_W-1:0] res_data;
    logic             res_ovf;

    typedef struct {
        longint data;
        bit     ovf;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    bit   rr_rand  = 1'b0;

    csa5_accum_seq #(.ACC_W(ACC_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_last   (in_last),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_data  (res_data),
        .res_ovf   (res_ovf)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Monitor: pops the oldest expected sum whenever a result handshake is about to occur.
    always @(negedge clk) begin
        if (!rst && res_valid && res_ready) begin
            if (sb.size() == 0) begin
                check("unexpected_result", 1, 0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("res_data", 64'(res_data), 64'(e.data));
                check("res_ovf", 64'(res_ovf), 64'(e.ovf));
            end
        end
    end

    always @(posedge clk) begin
        if (rr_rand) begin
            #1;
            res_ready = ($urandom_range(0, 3) != 0);
        end
    end

    task automatic send_op(input int d, input bit last);
        int cnt;
        in_valid = 1'b1;
        in_data  = 14'(d);
        in_last  = last;
        cnt = 0;
        while (!in_ready && cnt < 300) begin
            step();
            cnt++;
        end
        if (cnt >= 300) check("accept_timeout", 0, 1);
        step();
        in_valid = 1'b0;
        in_last  = 1'b0;
        in_data  = 14'($urandom);
    endtask

    function automatic exp_t model(input int ops[$]);
        exp_t   e;
        longint total = 0;
        foreach (ops[i]) total += ops[i];
        e.data = total % MOD;
        e.ovf  = (total >= MOD);
        return e;
    endfunction

    task automatic send_sum(input int ops[$], input bit gaps, input bit chk_gap);
        sb.push_back(model(ops));
        for (int i = 0; i < ops.size(); i++) begin
            send_op(ops[i], i == ops.size() - 1);
            if (chk_gap && (i % 5 == 4) && i != ops.size() - 1) begin
                check("gap_ready_c1", 64'(in_ready), 0);
                step();
                check("gap_ready_c2", 64'(in_ready), 0);
                step();
                check("gap_ready_c3", 64'(in_ready), 1);
            end
            if (gaps) repeat ($urandom_range(0, 2)) step();
        end
    endtask

    task automatic drain(input int limit);
        int cnt = 0;
        while (sb.size() != 0 && cnt < limit) begin
            step();
            cnt++;
        end
        check("drain_pending", 64'(sb.size()), 0);
        step();
    endtask

    initial begin
        int q[$];
        int cnt;

        rst = 1'b1; in_valid = 1'b0; in_last = 1'b0; in_data = '0; res_ready = 1'b1;
        step(); step();
        rst = 1'b0;
        check("rst_in_ready", 64'(in_ready), 1);
        check("rst_res_valid", 64'(res_valid), 0);
        check("rst_res_data", 64'(res_data), 0);
        check("rst_res_ovf", 64'(res_ovf), 0);

        // Five operands, with latency from the final accept.
        q = '{1, 2, 3, 4, 5};
        sb.push_back(model(q));
        for (int i = 1; i <= 4; i++) send_op(i, 1'b0);
        send_op(5, 1'b1);
        check("lat_valid_c1", 64'(res_valid), 0);
        check("lat_ready_c1", 64'(in_ready), 0);
        step();
        check("lat_valid_c2", 64'(res_valid), 0);
        step();
        check("lat_valid_c3", 64'(res_valid), 1);
        check("lat_data_c3", 64'(res_data), 15);
        drain(50);

        q = '{16383, 16383, 16383};
        send_sum(q, 1'b0, 1'b0);
        drain(50);

        q = {};
        repeat (12) q.push_back(16383);
        send_sum(q, 1'b0, 1'b1);
        drain(50);

        q = {};
        repeat (20) q.push_back(16383);
        send_sum(q, 1'b0, 1'b0);
        q = '{1, 1};
        send_sum(q, 1'b0, 1'b0);
        drain(100);

        // Backpressure in DONE.
        res_ready = 1'b0;
        q = '{100, 200, 300};
        send_sum(q, 1'b0, 1'b0);
        cnt = 0;
        while (!res_valid && cnt < 50) begin
            step();
            cnt++;
        end
        for (int i = 0; i < 4; i++) begin
            check("bp_valid", 64'(res_valid), 1);
            check("bp_data", 64'(res_data), 600);
            check("bp_in_ready", 64'(in_ready), 0);
            step();
        end
        res_ready = 1'b1;
        step();
        q = '{42};
        sb.push_back(model(q));
        in_valid = 1'b1; in_data = 14'd42; in_last = 1'b1;
        check("post_hs_ready", 64'(in_ready), 1);
        step();
        in_valid = 1'b0; in_last = 1'b0;
        check("post_hs_accepted", 64'(in_ready), 0);
        drain(50);

        // Reset mid-group.
        send_op(7, 1'b0);
        send_op(8, 1'b0);
        send_op(9, 1'b0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("midrst_valid", 64'(res_valid), 0);
        check("midrst_ready", 64'(in_ready), 1);
        check("midrst_data", 64'(res_data), 0);
        q = '{10};
        send_sum(q, 1'b0, 1'b0);
        drain(50);

        // Randomized sums with idle gaps and random result backpressure.
        rr_rand = 1'b1;
        for (int s = 0; s < 25; s++) begin
            int len;
            len = $urandom_range(1, 25);
            q = {};
            for (int i = 0; i < len; i++) begin
                if ($urandom_range(0, 3) == 0) q.push_back(16383);
                else q.push_back(int'($urandom_range(0, 16383)));
            end
            send_sum(q, 1'b1, 1'b0);
        end
        drain(3000);
        rr_rand = 1'b0;
        step();
        res_ready = 1'b1;
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
